// File: rtl/ndn_router_pkg.sv
// ndn_router_pkg: shared constants and types for the NDN router SPI front end
package ndn_router_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'h00;
  typedef enum logic {IDLE, ACTIVE} spi_state_t;
endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous byte FIFO; a push into a full FIFO only lands when a pop frees a slot that cycle
module spi_tx_fifo import ndn_router_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [SPI_BYTE_W-1:0]     din_i,
  input  logic                      pop_i,
  output logic [SPI_BYTE_W-1:0]     dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [SPI_BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 slave bridging board pins to the FIB byte streams.
// SPI_TX_FIFO_EN selects a TX_DEPTH-entry TX FIFO; otherwise TX uses one holding register.
module spi_slave_port import ndn_router_pkg::*; #(
  parameter int unsigned TX_DEPTH = 4,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  RX_valid,
  output logic [SPI_BYTE_W-1:0] data_SPI_to_FIB,
  input  logic                  FIB_to_SPI_data_flag,
  input  logic [SPI_BYTE_W-1:0] data_FIB_to_SPI,
  output logic                  tx_full,
  output logic                  tx_overflow,
  output logic                  frame_active
);
  spi_state_t state_q, state_d;
  logic [1:0] sclk_sq, cs_sq, mosi_sq;
  logic sclk_prev_q, active, enter, rise, fall, load, pop, full, empty;
  logic [SPI_BYTE_W-1:0] rx_shift_q, rx_data_q, tx_shift_q, head;
  logic [2:0] rx_cnt_q, tx_bit_q;
  logic rx_done_q, rx_valid_q, ovf_q;
  assign miso = active & tx_shift_q[7];
  assign RX_valid = rx_valid_q;
  assign data_SPI_to_FIB = rx_data_q;
  assign tx_overflow = ovf_q;
  assign frame_active = ~cs_sq[1];
  always_comb begin
    state_d = cs_sq[1] ? IDLE : ACTIVE;
    active = state_q == ACTIVE;
    enter = state_q == IDLE && !cs_sq[1];
    rise = active && sclk_sq[1] && !sclk_prev_q;
    fall = active && !sclk_sq[1] && sclk_prev_q;
    load = enter || (fall && tx_bit_q == 3'd7);
    pop = load && !empty;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sq <= '0;
      cs_sq <= '1;
      mosi_sq <= '0;
      sclk_prev_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      sclk_sq <= {sclk_sq[0], sclk};
      cs_sq <= {cs_sq[0], cs_n};
      mosi_sq <= {mosi_sq[0], mosi};
      sclk_prev_q <= sclk_sq[1];
      state_q <= state_d;
    end
  end
  // Completed byte is published one cycle after the 8th sample lands in rx_shift_q
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_shift_q <= '0;
      rx_cnt_q <= '0;
      rx_done_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      rx_done_q <= rise && rx_cnt_q == 3'd7;
      rx_valid_q <= rx_done_q;
      if (rx_done_q) rx_data_q <= rx_shift_q;
      if (rise) rx_shift_q <= {rx_shift_q[SPI_BYTE_W-2:0], mosi_sq[1]};
      rx_cnt_q <= active ? rx_cnt_q + {2'b0, rise} : 3'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_shift_q <= '0;
      tx_bit_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (load) tx_shift_q <= empty ? IDLE_BYTE : head;
      else if (fall) tx_shift_q <= {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
      tx_bit_q <= active ? tx_bit_q + {2'b0, fall} : 3'd0;
      if (FIB_to_SPI_data_flag && full && !pop) ovf_q <= 1'b1;
    end
  end
`ifdef SPI_TX_FIFO_EN
  localparam int CW = $clog2(TX_DEPTH) + 1;
  logic [CW-1:0] fifo_cnt;
  spi_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (FIB_to_SPI_data_flag),
    .din_i   (data_FIB_to_SPI),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );
  assign tx_full = fifo_cnt == CW'(TX_DEPTH);
`else
  logic [SPI_BYTE_W-1:0] hold_q;
  logic hold_v_q, take;
  assign head = hold_q;
  assign full = hold_v_q;
  assign empty = ~hold_v_q;
  assign tx_full = hold_v_q;
  assign take = FIB_to_SPI_data_flag & (~hold_v_q | pop);
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      hold_v_q <= 1'b0;
    end else begin
      if (take) hold_q <= data_FIB_to_SPI;
      hold_v_q <= take | (hold_v_q & ~pop);
    end
  end
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed bench for spi_slave_port; TX capacity follows SPI_TX_FIFO_EN
module tb_spi_slave_port;
`ifdef SPI_TX_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  logic clk = 0, rst = 0, sclk = 0, cs_n = 1, mosi = 0, flag = 0;
  logic [7:0] din = 0;
  logic miso, rx_valid, tx_full, tx_overflow, frame_active;
  logic [7:0] rx_data;
  int tot = 0, bad = 0, cyc = 0, rx_n = 0, rx_cyc = 0, rise8 = 0;
  logic [7:0] rx_last = 0;

  spi_slave_port #(.TX_DEPTH(4), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .RX_valid(rx_valid), .data_SPI_to_FIB(rx_data),
    .FIB_to_SPI_data_flag(flag), .data_FIB_to_SPI(din),
    .tx_full(tx_full), .tx_overflow(tx_overflow), .frame_active(frame_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rx_valid) begin rx_n++; rx_last = rx_data; rx_cyc = cyc; end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    flag = 1; din = b; tick(1); flag = 0;
  endtask

  task automatic do_reset;
    rst = 0; tick(2); rst = 1; tick(2);
  endtask

  task automatic frame_start;
    cs_n = 0; tick(6);
  endtask

  task automatic frame_end;
    tick(4); cs_n = 1; tick(6);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i]; tick(4);
      sclk = 1; r[i] = miso; rise8 = cyc; tick(4);
      sclk = 0;
    end
  endtask

  task automatic test_reset;
    rst = 0; tick(3);
    tot++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", miso); end
    tot++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    tot++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    tot++; if (tx_full !== 1'b0) begin bad++; $display("FAIL reset_tx_full got=%b want=0", tx_full); end
    tot++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", tx_overflow); end
    tot++; if (frame_active !== 1'b0) begin bad++; $display("FAIL reset_frame_active got=%b want=0", frame_active); end
    rst = 1; tick(2);
  endtask

  task automatic test_rx;
    logic [7:0] r;
    int n0;
    n0 = rx_n;
    frame_start;
    tot++; if (frame_active !== 1'b1) begin bad++; $display("FAIL rx_frame_active got=%b want=1", frame_active); end
    spi_bits(8'hA5, 8, r); tick(2);
    tot++; if (rx_n - n0 !== 1) begin bad++; $display("FAIL rx_pulses got=%0d want=1", rx_n - n0); end
    tot++; if (rx_last !== 8'hA5) begin bad++; $display("FAIL rx_byte got=%h want=a5", rx_last); end
    tot++; if (rx_cyc < rise8 || rx_cyc - rise8 > 5) begin bad++; $display("FAIL rx_latency got=%0d want<=5", rx_cyc - rise8); end
    tot++; if (r !== 8'h00) begin bad++; $display("FAIL rx_idle_miso got=%h want=00", r); end
    frame_end;
    tot++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL rx_hold got=%h want=a5", rx_data); end
    tot++; if (frame_active !== 1'b0) begin bad++; $display("FAIL rx_frame_end got=%b want=0", frame_active); end
  endtask

  task automatic test_tx;
    logic [7:0] r;
    logic [7:0] exp_tx [3] = '{8'h3C, 8'hC3, 8'h00};
    logic [7:0] host [3] = '{8'h11, 8'h22, 8'h33};
    push(8'h3C);
    frame_start;
    push(8'hC3);
    for (int k = 0; k < 3; k++) begin
      spi_bits(host[k], 8, r); tick(2);
      tot++; if (r !== exp_tx[k]) begin bad++; $display("FAIL tx_byte%0d got=%h want=%h", k, r, exp_tx[k]); end
      tot++; if (rx_last !== host[k]) begin bad++; $display("FAIL tx_rx_byte%0d got=%h want=%h", k, rx_last, host[k]); end
    end
    frame_end;
    tot++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL tx_no_overflow got=%b want=0", tx_overflow); end
  endtask

  task automatic test_abort;
    logic [7:0] r;
    int n0;
    n0 = rx_n;
    frame_start;
    spi_bits(8'hFF, 5, r);
    frame_end;
    tot++; if (rx_n !== n0) begin bad++; $display("FAIL abort_no_rx got=%0d want=%0d", rx_n, n0); end
    frame_start;
    spi_bits(8'h12, 8, r); tick(2);
    frame_end;
    tot++; if (rx_n - n0 !== 1) begin bad++; $display("FAIL abort_next_pulses got=%0d want=1", rx_n - n0); end
    tot++; if (rx_last !== 8'h12) begin bad++; $display("FAIL abort_next_byte got=%h want=12", rx_last); end
  endtask

  task automatic test_overflow;
    logic [7:0] r;
    logic [7:0] e;
    do_reset;
    for (int k = 0; k < 5; k++) begin
      push(8'h50 + 8'(k));
      tot++; if (tx_full !== (k + 1 >= D)) begin bad++; $display("FAIL ovf_full%0d got=%b want=%b", k, tx_full, k + 1 >= D); end
      tot++; if (tx_overflow !== (k + 1 > D)) begin bad++; $display("FAIL ovf_flag%0d got=%b want=%b", k, tx_overflow, k + 1 > D); end
    end
    frame_start;
    for (int k = 0; k <= D; k++) begin
      e = (k < D) ? 8'h50 + 8'(k) : 8'h00;
      spi_bits(8'hEE, 8, r);
      tot++; if (r !== e) begin bad++; $display("FAIL ovf_read%0d got=%h want=%h", k, r, e); end
    end
    frame_end;
    tot++; if (tx_full !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", tx_full); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    push(8'hA1); push(8'hB2); push(8'hC3);
    frame_start;
    spi_bits(8'hF0, 3, r);
    rst = 0; cs_n = 1; tick(2);
    tot++; if (miso !== 1'b0) begin bad++; $display("FAIL mid_miso got=%b want=0", miso); end
    tot++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rx_valid got=%b want=0", rx_valid); end
    tot++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data got=%h want=00", rx_data); end
    tot++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b want=0", tx_overflow); end
    tot++; if (frame_active !== 1'b0) begin bad++; $display("FAIL mid_frame_active got=%b want=0", frame_active); end
    rst = 1; tick(2);
    tot++; if (tx_full !== 1'b0) begin bad++; $display("FAIL mid_tx_full got=%b want=0", tx_full); end
    frame_start;
    spi_bits(8'h00, 8, r);
    tot++; if (r !== 8'h00) begin bad++; $display("FAIL mid_next_miso got=%h want=00", r); end
    frame_end;
  endtask

  task automatic test_full_push_pop;
    logic [7:0] r;
    logic [7:0] e;
    do_reset;
    for (int k = 0; k < D; k++) push(8'h60 + 8'(k));
    tot++; if (tx_full !== 1'b1) begin bad++; $display("FAIL pp_full got=%b want=1", tx_full); end
    cs_n = 0; tick(2);
    flag = 1; din = 8'h7E; tick(1); flag = 0;
    tot++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow got=%b want=0", tx_overflow); end
    tot++; if (tx_full !== 1'b1) begin bad++; $display("FAIL pp_still_full got=%b want=1", tx_full); end
    tick(3);
    for (int k = 0; k <= D; k++) begin
      e = (k < D) ? 8'h60 + 8'(k) : 8'h7E;
      spi_bits(8'h00, 8, r);
      tot++; if (r !== e) begin bad++; $display("FAIL pp_read%0d got=%h want=%h", k, r, e); end
    end
    frame_end;
    tot++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow_end got=%b want=0", tx_overflow); end
  endtask

  initial begin
    test_reset;
    test_rx;
    test_tx;
    test_abort;
    test_overflow;
    test_reset_mid;
    test_full_push_pop;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
